mux_arb_nto1: RTL and testbench

//  Parametrised N-to-1 datapath multiplexer with one registered output stage
//  and valid/ready handshakes on every input and on the output.
//  Two source-selection modes:
//  - Direct: an external select picks the source, as the 4:1 bus muxes do.
//  - Round-robin: the block arbitrates among the requesting inputs.

---
 rtl/mux_arb_nto1.sv | 132 +++++++++++++
 tb/tb_mux_arb_nto1.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_nto1.sv
// ---------------------------------------------------------------------------
// mux_arb_nto1
//   N-to-1 datapath multiplexer with a single registered output stage and
//   valid/ready handshakes on every input and on the output. The source is
//   either picked by an external select (direct mode) or chosen by a
//   round-robin arbiter over the requesting inputs.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       0 = direct select, 1 = round-robin arbitration
//   sel        source channel in direct mode (ignored in round-robin mode)
//   in_data    flat inputs, channel k = in_data[k*WIDTH +: WIDTH]
//   in_valid   per-channel data valid
//   in_ready   per-channel accept, one-hot or zero, combinational
//   out_data   registered output data
//   out_valid  output register holds a word
//   out_ready  downstream accepts the word
//   out_src    index of the channel that supplied out_data
// ---------------------------------------------------------------------------
module mux_arb_nto1 #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
);

    logic              load_s;
    logic              grant_vld_s;
    logic [SEL_W-1:0]  grant_idx_s;
    logic [WIDTH-1:0]  grant_data_s;
    int                scan_idx_s;

    logic [SEL_W-1:0]  last_grant_r;
    logic [WIDTH-1:0]  out_data_r;
    logic              out_valid_r;
    logic [SEL_W-1:0]  out_src_r;

    // The output stage can take a new word when empty or being drained.
    assign load_s = !out_valid_r || out_ready;

    // Grant selection: direct select or round-robin scan after last_grant.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        scan_idx_s  = 0;
        if (mode == 1'b0) begin
            // Comparing against each legal index means an out-of-range
            // select simply matches nothing.
            for (int k = 0; k < NUM_IN; k++) begin
                if ((SEL_W'(k) == sel) && in_valid[k]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = SEL_W'(k);
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
        end else begin
            // Offsets 1..NUM_IN visit every channel once, last_grant last.
            for (int i = 1; i <= NUM_IN; i++) begin
                scan_idx_s = (int'(last_grant_r) + i) % NUM_IN;
                if (!grant_vld_s && in_valid[scan_idx_s]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = SEL_W'(scan_idx_s);
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
        end
    end

    // Data multiplexer driven by the granted index.
    always_comb begin
        grant_data_s = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (SEL_W'(k) == grant_idx_s) begin
                grant_data_s = in_data[k*WIDTH +: WIDTH];
            end else begin
                grant_data_s = grant_data_s;
            end
        end
    end

    // Accept only the granted channel, and only when the stage can load.
    // Gating with rst_n keeps every in_ready low while reset is held.
    always_comb begin
        in_ready = '0;
        if (rst_n && load_s && grant_vld_s) begin
            in_ready[grant_idx_s] = 1'b1;
        end else begin
            in_ready = '0;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r   <= '0;
            out_valid_r  <= 1'b0;
            out_src_r    <= '0;
            last_grant_r <= SEL_W'(NUM_IN - 1);
        end else if (load_s) begin
            if (grant_vld_s) begin
                out_data_r  <= grant_data_s;
                out_src_r   <= grant_idx_s;
                out_valid_r <= 1'b1;
                // Direct-mode traffic leaves the arbitration history alone.
                if (mode) begin
                    last_grant_r <= grant_idx_s;
                end
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_src   = out_src_r;

endmodule

// File: tb/tb_mux_arb_nto1.sv
`timescale 1ns/1ps
module tb_mux_arb_nto1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Four-channel instance
    logic        mode;
    logic [1:0]  sel;
    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_src;

    // Three-channel instance for the out-of-range select case
    logic        mode3;
    logic [1:0]  sel3;
    logic [47:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [15:0] out_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic [1:0]  out_src3;

    int checks   = 0;
    int failures = 0;

    logic [17:0] sb4[$];
    logic [17:0] sb3[$];
    logic [17:0] e4;
    logic [17:0] e3;
    logic [15:0] chan_val[4];

    mux_arb_nto1 #(.WIDTH(16), .NUM_IN(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_src(out_src)
    );

    mux_arb_nto1 #(.WIDTH(16), .NUM_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_src(out_src3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the four-channel instance: every output handshake pops one word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb4_unexpected actual_data=%0h actual_src=%0d expected=none", out_data, out_src);
            end else begin
                e4 = sb4.pop_front();
                check("sb4_data", 32'(out_data), 32'(e4[17:2]));
                check("sb4_src", 32'(out_src), 32'(e4[1:0]));
            end
        end
    end

    // Monitor for the three-channel instance.
    always @(negedge clk) begin
        if (rst_n && out_valid3 && out_ready3) begin
            if (sb3.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb3_unexpected actual_data=%0h actual_src=%0d expected=none", out_data3, out_src3);
            end else begin
                e3 = sb3.pop_front();
                check("sb3_data", 32'(out_data3), 32'(e3[17:2]));
                check("sb3_src", 32'(out_src3), 32'(e3[1:0]));
            end
        end
    end

    initial begin
        chan_val[0] = 16'h1111;
        chan_val[1] = 16'h2222;
        chan_val[2] = 16'h3333;
        chan_val[3] = 16'h4444;

        rst_n      = 1'b0;
        mode       = 1'b0;
        sel        = 2'd0;
        in_data    = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        in_valid   = 4'hF;
        out_ready  = 1'b1;
        mode3      = 1'b0;
        sel3       = 2'd0;
        in_data3   = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        in_valid3  = 3'b000;
        out_ready3 = 1'b1;

        // Reset state
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);

        // Direct select of channel 2
        rst_n = 1'b1;
        mode  = 1'b0;
        sel   = 2'd2;
        #1;
        check("direct_in_ready", 32'(in_ready), 32'b0100);
        sb4.push_back({16'h3333, 2'd2});
        step();
        check("direct_out_valid", 32'(out_valid), 32'd1);

        // Round-robin with all channels valid: 0,1,2,3,0,1,2,3
        mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("rr_in_ready", 32'(in_ready), 32'(4'b0001 << (i % 4)));
            sb4.push_back({chan_val[i % 4], 2'(i % 4)});
            step();
        end

        // Sparse round-robin: move last_grant to 1, then 4'b1010 -> 3, 1
        in_valid = 4'b0010;
        #1;
        check("sparse_prep_ready", 32'(in_ready), 32'b0010);
        sb4.push_back({16'h2222, 2'd1});
        step();
        in_valid = 4'b1010;
        #1;
        check("sparse_ready_ch3", 32'(in_ready), 32'b1000);
        sb4.push_back({16'h4444, 2'd3});
        step();
        #1;
        check("sparse_ready_ch1", 32'(in_ready), 32'b0010);
        sb4.push_back({16'h2222, 2'd1});
        step();
        in_valid = 4'b0000;
        #1;
        check("sparse_idle_ready", 32'(in_ready), 32'd0);
        step();
        check("sparse_drop_valid", 32'(out_valid), 32'd0);
        check("sparse_hold_data", 32'(out_data), 32'h2222);
        check("sparse_hold_src", 32'(out_src), 32'd1);

        // Backpressure: last_grant=1 so channel 2 wins first
        in_valid = 4'hF;
        #1;
        check("bp_first_ready", 32'(in_ready), 32'b0100);
        sb4.push_back({16'h3333, 2'd2});
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_stall_ready", 32'(in_ready), 32'd0);
            check("bp_stall_valid", 32'(out_valid), 32'd1);
            check("bp_stall_data", 32'(out_data), 32'h3333);
            check("bp_stall_src", 32'(out_src), 32'd2);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'b1000);
        sb4.push_back({16'h4444, 2'd3});
        step();
        check("bp_no_bubble_valid", 32'(out_valid), 32'd1);
        check("bp_no_bubble_data", 32'(out_data), 32'h4444);
        in_valid = 4'b0000;
        step();
        check("bp_drain_valid", 32'(out_valid), 32'd0);

        // Out-of-range select on the three-channel instance
        in_valid3 = 3'b111;
        sel3      = 2'd0;
        #1;
        check("oor_inrange_ready", 32'(in_ready3), 32'b001);
        sb3.push_back({16'hAAAA, 2'd0});
        step();
        sel3 = 2'd3;
        #1;
        check("oor_ready", 32'(in_ready3), 32'd0);
        check("oor_word_present", 32'(out_valid3), 32'd1);
        step();
        check("oor_valid_falls", 32'(out_valid3), 32'd0);
        check("oor_data_held", 32'(out_data3), 32'hAAAA);

        // Asynchronous reset with a word held in the output register
        mode     = 1'b0;
        sel      = 2'd1;
        in_valid = 4'hF;
        #1;
        check("arst_pre_ready", 32'(in_ready), 32'b0010);
        step();
        out_ready = 1'b0;
        #1;
        check("arst_pre_valid", 32'(out_valid), 32'd1);
        check("arst_pre_data", 32'(out_data), 32'h2222);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_out_src", 32'(out_src), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        check("sb4_drained", 32'(sb4.size()), 32'd0);
        check("sb3_drained", 32'(sb3.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
